// File: rtl/kong_game_ctrl.sv
// kong_game_ctrl: round-lifecycle sequencer for the Kong player datapath.
// Gates the movement block (reset + frame strobe) and tracks lives/level for the HUD.
`default_nettype none

module kong_game_ctrl #(
  parameter int START_LIVES  = 3,
  parameter int MAX_LEVEL    = 3,
  parameter int READY_FRAMES = 90,
  parameter int DEATH_FRAMES = 60,
  parameter int WIN_FRAMES   = 120,
  parameter int FALL_Y       = 470
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        start_key,
  input  logic        collision_enemy,
  input  logic        collision_goal,
  input  logic [10:0] kong_topLeftY,
  output logic        kong_resetN,
  output logic        kong_frame_en,
  output logic [1:0]  lives,
  output logic [1:0]  level,
  output logic [2:0]  game_state,
  output logic        game_won
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READY     = 3'd1,
    S_PLAY      = 3'd2,
    S_DYING     = 3'd3,
    S_WIN       = 3'd4,
    S_GAME_OVER = 3'd5
  } state_t;

  localparam logic [7:0]         READY_CNT = 8'(READY_FRAMES);
  localparam logic [7:0]         DEATH_CNT = 8'(DEATH_FRAMES);
  localparam logic [7:0]         WIN_CNT   = 8'(WIN_FRAMES);
  localparam logic [1:0]         LIVES_INIT = 2'(START_LIVES);
  localparam logic [1:0]         LEVEL_LAST = 2'(MAX_LEVEL);
  localparam logic signed [10:0] FALL_Y_S  = 11'(FALL_Y);

  state_t     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [1:0] lives_q, lives_d;
  logic [1:0] level_q, level_d;
  logic       game_won_q, game_won_d;
  logic       kong_resetn_q, kong_resetn_d;
  logic       enemy_seen_q, enemy_seen_d;
  logic       goal_seen_q, goal_seen_d;
  logic       start_seen_q, start_seen_d;
  logic       fall;
  logic       cnt_last;

  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    lives_d       = lives_q;
    level_d       = level_q;
    game_won_d    = game_won_q;
    fall          = startOfFrame && ($signed(kong_topLeftY) >= FALL_Y_S);
    cnt_last      = (frame_cnt_q == 8'd1);

    // The strobe cycle restarts each latch with its own input, so an event
    // coinciding with startOfFrame is counted in the frame that follows.
    if (startOfFrame) begin
      enemy_seen_d = collision_enemy;
      goal_seen_d  = collision_goal;
      start_seen_d = start_key;
    end else begin
      enemy_seen_d = enemy_seen_q | collision_enemy;
      goal_seen_d  = goal_seen_q | collision_goal;
      start_seen_d = start_seen_q | start_key;
    end

    if (startOfFrame) begin
      unique case (state_q)
        S_IDLE, S_GAME_OVER: begin
          if (start_seen_q) begin
            state_d     = S_READY;
            lives_d     = LIVES_INIT;
            level_d     = 2'd1;
            game_won_d  = 1'b0;
            frame_cnt_d = READY_CNT;
          end
        end
        S_READY: begin
          if (cnt_last) state_d = S_PLAY;
          else          frame_cnt_d = frame_cnt_q - 8'd1;
        end
        S_PLAY: begin
          if (goal_seen_q) begin
            state_d     = S_WIN;
            frame_cnt_d = WIN_CNT;
          end else if (enemy_seen_q || fall) begin
            state_d     = S_DYING;
            lives_d     = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
            frame_cnt_d = DEATH_CNT;
          end
        end
        S_DYING: begin
          if (cnt_last) begin
            if (lives_q == 2'd0) begin
              state_d = S_GAME_OVER;
            end else begin
              state_d     = S_READY;
              frame_cnt_d = READY_CNT;
            end
          end else begin
            frame_cnt_d = frame_cnt_q - 8'd1;
          end
        end
        S_WIN: begin
          if (cnt_last) begin
            if (level_q == LEVEL_LAST) begin
              state_d    = S_GAME_OVER;
              game_won_d = 1'b1;
            end else begin
              state_d     = S_READY;
              level_d     = level_q + 2'd1;
              frame_cnt_d = READY_CNT;
            end
          end else begin
            frame_cnt_d = frame_cnt_q - 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Released on the edge entering PLAY; still released (frozen) while dying.
    kong_resetn_d = (state_d == S_PLAY) || (state_d == S_DYING);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= S_IDLE;
      frame_cnt_q   <= 8'd0;
      lives_q       <= 2'd0;
      level_q       <= 2'd1;
      game_won_q    <= 1'b0;
      kong_resetn_q <= 1'b0;
      enemy_seen_q  <= 1'b0;
      goal_seen_q   <= 1'b0;
      start_seen_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      lives_q       <= lives_d;
      level_q       <= level_d;
      game_won_q    <= game_won_d;
      kong_resetn_q <= kong_resetn_d;
      enemy_seen_q  <= enemy_seen_d;
      goal_seen_q   <= goal_seen_d;
      start_seen_q  <= start_seen_d;
    end
  end

  assign kong_resetN   = kong_resetn_q;
  assign kong_frame_en = startOfFrame && (state_q == S_PLAY);
  assign lives         = lives_q;
  assign level         = level_q;
  assign game_state    = state_q;
  assign game_won      = game_won_q;

endmodule

`default_nettype wire

// File: tb/tb_kong_game_ctrl.sv
// Testbench for kong_game_ctrl: scoreboard of expected HUD/state snapshots.
// Instance a uses defaults; instance b uses MAX_LEVEL=1 to cover the game-won path.
`default_nettype none

module tb_kong_game_ctrl;

  localparam int GAP = 8;

  logic        clk = 1'b0;
  logic        resetN, sof, start_key, col_e, col_g;
  logic [10:0] y;

  logic       a_kr, a_fe, a_won, b_kr, b_fe, b_won;
  logic [1:0] a_lives, a_level, b_lives, b_level;
  logic [2:0] a_state, b_state;

  always #5 clk = ~clk;

  kong_game_ctrl dut_a (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .start_key(start_key),
    .collision_enemy(col_e), .collision_goal(col_g), .kong_topLeftY(y),
    .kong_resetN(a_kr), .kong_frame_en(a_fe), .lives(a_lives), .level(a_level),
    .game_state(a_state), .game_won(a_won)
  );

  kong_game_ctrl #(.MAX_LEVEL(1)) dut_b (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .start_key(start_key),
    .collision_enemy(col_e), .collision_goal(col_g), .kong_topLeftY(y),
    .kong_resetN(b_kr), .kong_frame_en(b_fe), .lives(b_lives), .level(b_level),
    .game_state(b_state), .game_won(b_won)
  );

  typedef struct {
    string      name;
    logic [8:0] v;   // {state, lives, level, kong_resetN, game_won}
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [8:0] snap(input logic [2:0] s, input logic [1:0] l,
                                      input logic [1:0] lv, input logic kr, input logic w);
    return {s, l, lv, kr, w};
  endfunction

  task automatic push(input string n, input logic [8:0] v);
    exp_t x;
    x.name = n;
    x.v    = v;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: strobe cycle (optionally with an enemy hit in it), then GAP-1 quiet cycles.
  task automatic frame(input logic hit_in_sof, output logic fe);
    sof   = 1'b1;
    col_e = hit_in_sof;
    #1 fe = a_fe;
    @(posedge clk);
    #1;
    sof   = 1'b0;
    col_e = 1'b0;
    repeat (GAP - 1) tick();
  endtask

  task automatic frames(input int n, output logic any_fe);
    logic fe;
    any_fe = 1'b0;
    for (int i = 0; i < n; i++) begin
      frame(1'b0, fe);
      any_fe = any_fe | fe;
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0; sof = 1'b1; start_key = 1'b0; col_e = 1'b0; col_g = 1'b0; y = 11'd0;
    repeat (3) tick();
    push("reset_a", snap(3'd0, 2'd0, 2'd1, 1'b0, 1'b0));
    push("reset_b", snap(3'd0, 2'd0, 2'd1, 1'b0, 1'b0));
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
    e = sb.pop_front(); n_cmp++;
    if (snap(b_state, b_lives, b_level, b_kr, b_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(b_state, b_lives, b_level, b_kr, b_won), e.v);
    end
    n_cmp++;
    if (a_fe !== 1'b0) begin
      n_err++; $display("FAIL reset_frame_en: got %b want 0", a_fe);
    end
    sof = 1'b0;
    tick();
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_start();
    logic fe, any;
    int   pulses;
    frame(1'b0, fe);
    push("idle_no_start", snap(3'd0, 2'd0, 2'd1, 1'b0, 1'b0));
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
    start_key = 1'b1; tick(); start_key = 1'b0; tick();
    push("start_ready", snap(3'd1, 2'd3, 2'd1, 1'b0, 1'b0));
    frame(1'b0, fe);
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
    push("ready_hold_89", snap(3'd1, 2'd3, 2'd1, 1'b0, 1'b0));
    frames(89, any);
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
    push("ready_to_play", snap(3'd2, 2'd3, 2'd1, 1'b1, 1'b0));
    frame(1'b0, fe);
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      frame(1'b0, fe);
      if (fe === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 3) begin
      n_err++; $display("FAIL play_frame_en: got %0d pulses want 3", pulses);
    end
  endtask

  task automatic test_enemy();
    logic fe, any;
    tick(); col_e = 1'b1; tick(); col_e = 1'b0;
    push("enemy_dying", snap(3'd3, 2'd2, 2'd1, 1'b1, 1'b0));
    frame(1'b0, fe);
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
    n_cmp++;
    if (fe !== 1'b1) begin
      n_err++; $display("FAIL exit_play_frame_en: got %b want 1", fe);
    end
    push("dying_hold_59", snap(3'd3, 2'd2, 2'd1, 1'b1, 1'b0));
    frames(59, any);
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
    push("dying_to_ready", snap(3'd1, 2'd2, 2'd1, 1'b0, 1'b0));
    frame(1'b0, fe);
    any = any | fe;
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
    n_cmp++;
    if (any !== 1'b0) begin
      n_err++; $display("FAIL dying_frame_en: got %b want 0", any);
    end
    push("respawn_play", snap(3'd2, 2'd2, 2'd1, 1'b1, 1'b0));
    frames(90, any);
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
  endtask

  task automatic test_fall();
    logic fe, any;
    logic [10:0] ys [3];
    logic [8:0]  ws [3];
    ys[0] = 11'd469;   ws[0] = snap(3'd2, 2'd2, 2'd1, 1'b1, 1'b0);
    ys[1] = 11'h7FB;   ws[1] = snap(3'd2, 2'd2, 2'd1, 1'b1, 1'b0);
    ys[2] = 11'd470;   ws[2] = snap(3'd3, 2'd1, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      y = ys[i];
      push($sformatf("fall_y_%0d", $signed(ys[i])), ws[i]);
      frame(1'b0, fe);
      e = sb.pop_front(); n_cmp++;
      if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
        n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
      end
    end
    y = 11'd0;
    push("fall_back_to_play", snap(3'd2, 2'd1, 2'd1, 1'b1, 1'b0));
    frames(150, any);
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
  endtask

  task automatic test_sof_collision_game_over();
    logic fe, any;
    push("sof_hit_no_change", snap(3'd2, 2'd1, 2'd1, 1'b1, 1'b0));
    push("sof_hit_next_dying", snap(3'd3, 2'd0, 2'd1, 1'b1, 1'b0));
    frame(1'b1, fe);
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
    frame(1'b0, fe);
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
    frames(59, any);
    start_key = 1'b1;  // held through the transition into GAME_OVER
    push("game_over", snap(3'd5, 2'd0, 2'd1, 1'b0, 1'b0));
    frame(1'b0, fe);
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
    push("restart_ready", snap(3'd1, 2'd3, 2'd1, 1'b0, 1'b0));
    frame(1'b0, fe);
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
    frame(1'b0, fe);
    start_key = 1'b0;
    push("restart_ready_hold", snap(3'd1, 2'd3, 2'd1, 1'b0, 1'b0));
    frames(88, any);
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
    push("restart_play", snap(3'd2, 2'd3, 2'd1, 1'b1, 1'b0));
    frame(1'b0, fe);
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
  endtask

  task automatic test_goal_and_enemy();
    logic fe, any;
    tick(); col_e = 1'b1; col_g = 1'b1; tick(); col_e = 1'b0; col_g = 1'b0;
    push("win_a", snap(3'd4, 2'd3, 2'd1, 1'b0, 1'b0));
    push("win_b", snap(3'd4, 2'd3, 2'd1, 1'b0, 1'b0));
    frame(1'b0, fe);
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
    e = sb.pop_front(); n_cmp++;
    if (snap(b_state, b_lives, b_level, b_kr, b_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(b_state, b_lives, b_level, b_kr, b_won), e.v);
    end
    push("win_hold_119", snap(3'd4, 2'd3, 2'd1, 1'b0, 1'b0));
    frames(119, any);
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
    push("win_next_level_a", snap(3'd1, 2'd3, 2'd2, 1'b0, 1'b0));
    push("win_game_won_b", snap(3'd5, 2'd3, 2'd1, 1'b0, 1'b1));
    frame(1'b0, fe);
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
    e = sb.pop_front(); n_cmp++;
    if (snap(b_state, b_lives, b_level, b_kr, b_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(b_state, b_lives, b_level, b_kr, b_won), e.v);
    end
    push("level2_play", snap(3'd2, 2'd3, 2'd2, 1'b1, 1'b0));
    frames(90, any);
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
  endtask

  task automatic test_enemy_fall_then_reset();
    logic fe, any;
    tick(); col_e = 1'b1; tick(); col_e = 1'b0;
    y = 11'd470;
    push("enemy_and_fall_one_life", snap(3'd3, 2'd2, 2'd2, 1'b1, 1'b0));
    frame(1'b0, fe);
    y = 11'd0;
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
    frames(5, any);
    start_key = 1'b1; tick(); start_key = 1'b0;
    #2 resetN = 1'b0;
    #1;
    push("async_reset_in_dying", snap(3'd0, 2'd0, 2'd1, 1'b0, 1'b0));
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
    tick();
    resetN = 1'b1;
    tick();
    push("no_residual_start", snap(3'd0, 2'd0, 2'd1, 1'b0, 1'b0));
    frame(1'b0, fe);
    e = sb.pop_front(); n_cmp++;
    if (snap(a_state, a_lives, a_level, a_kr, a_won) !== e.v) begin
      n_err++; $display("FAIL %s: got %b want %b", e.name, snap(a_state, a_lives, a_level, a_kr, a_won), e.v);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_start();
    test_enemy();
    test_fall();
    test_sof_collision_game_over();
    test_goal_and_enemy();
    test_enemy_fall_then_reset();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
